axi_rt_resp_meter: RTL and testbench

Passive response-side monitor for an AXI4 link: counts outstanding writes and reads, meters read-data bytes returned per period, and flags transactions whose responses stall past a programmable timeout. It sits on the manager port downstream of the real-time unit, observing request/response structs without driving them. It is the response-direction counterpart to the request-side budget/throttle path: that path limits what is issued, this block measures what comes back.

---
 rtl/axi_rt_resp_meter.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_rt_resp_meter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rt_resp_meter.sv
// ---------------------------------------------------------------------------
// axi_rt_resp_meter
//
// Passive response-side monitor for an AXI4 manager port. It watches the
// request/response structs without driving them. It tracks outstanding
// writes and reads, counts read-data bytes per metering period, and raises
// sticky flags when a response stalls longer than a programmable timeout.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   mon_req_i        observed AXI request struct (valids of AW/AR, readies of B/R)
//   mon_resp_i       observed AXI response struct (readies of AW/AR, valids of B/R, R.last)
//   enable_i         enables the period FSM and the timeout counters
//   clear_i          synchronous clear of sticky flags, byte counters, period
//   period_i         metering period in cycles (0 = no snapshots)
//   timeout_i        stall limit in cycles (0 = timeout disabled)
//   w_outstanding_o  AW accepted, B not yet accepted
//   r_outstanding_o  AR accepted, last R not yet accepted
//   r_bytes_cur_o    read bytes in the current period (saturating)
//   r_bytes_o        read bytes of the last completed period
//   period_left_o    cycles left in the current period
//   w_timeout_o      sticky write-response timeout
//   r_timeout_o      sticky read-response timeout
//   protocol_error_o sticky over/underflow of the outstanding counters
// ---------------------------------------------------------------------------

package axi_rt_resp_meter_pkg;

  // Only the fields the monitor looks at are carried in the default structs.
  typedef struct packed {
    logic aw_valid;
    logic b_ready;
    logic ar_valid;
    logic r_ready;
  } req_t;

  typedef struct packed {
    logic last;
  } r_chan_t;

  typedef struct packed {
    logic    aw_ready;
    logic    b_valid;
    logic    ar_ready;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

module axi_rt_resp_meter #(
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned NumPending   = 4,
  parameter int unsigned PeriodWidth  = 16,
  parameter int unsigned TimeoutWidth = 16,
  parameter int unsigned BytesWidth   = 32,
  parameter type axi_req_t  = axi_rt_resp_meter_pkg::req_t,
  parameter type axi_resp_t = axi_rt_resp_meter_pkg::resp_t,
  localparam int unsigned OutWidth = ((NumPending + 1) > 1) ? $clog2(NumPending + 1) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  axi_req_t                mon_req_i,
  input  axi_resp_t               mon_resp_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [PeriodWidth-1:0]  period_i,
  input  logic [TimeoutWidth-1:0] timeout_i,
  output logic [OutWidth-1:0]     w_outstanding_o,
  output logic [OutWidth-1:0]     r_outstanding_o,
  output logic [BytesWidth-1:0]   r_bytes_cur_o,
  output logic [BytesWidth-1:0]   r_bytes_o,
  output logic [PeriodWidth-1:0]  period_left_o,
  output logic                    w_timeout_o,
  output logic                    r_timeout_o,
  output logic                    protocol_error_o
);

  localparam logic [OutWidth-1:0]   MaxPending = OutWidth'(NumPending);
  localparam logic [BytesWidth-1:0] BeatBytes  = BytesWidth'(DataWidth / 8);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  logic awHs, bHs, arHs, rbHs, rlHs;

  state_e                  state_q, state_d;
  logic [OutWidth-1:0]     wCnt_q, wCnt_d;
  logic [OutWidth-1:0]     rCnt_q, rCnt_d;
  logic [BytesWidth-1:0]   rBytesCur_q, rBytesCur_d;
  logic [BytesWidth-1:0]   rBytes_q, rBytes_d;
  logic [PeriodWidth-1:0]  periodLeft_q, periodLeft_d;
  logic [TimeoutWidth-1:0] wTcnt_q, wTcnt_d;
  logic [TimeoutWidth-1:0] rTcnt_q, rTcnt_d;
  logic                    wFlag_q, wFlag_d;
  logic                    rFlag_q, rFlag_d;
  logic                    perr_q, perr_d;

  logic                    wErr, rErr;
  logic [BytesWidth:0]     bytesSum;
  logic [BytesWidth-1:0]   bytesSat;
  logic                    timeoutOn;
  logic                    wStall, rStall;

  assign awHs = mon_req_i.aw_valid & mon_resp_i.aw_ready;
  assign bHs  = mon_resp_i.b_valid & mon_req_i.b_ready;
  assign arHs = mon_req_i.ar_valid & mon_resp_i.ar_ready;
  assign rbHs = mon_resp_i.r_valid & mon_req_i.r_ready;
  assign rlHs = rbHs & mon_resp_i.r.last;

  // Outstanding counters: a simultaneous +1/-1 cancels; a step past either
  // end is refused and reported as a protocol error.
  always_comb begin
    wCnt_d = wCnt_q;
    wErr   = 1'b0;
    if (awHs && !bHs) begin
      if (wCnt_q == MaxPending) wErr = 1'b1;
      else                      wCnt_d = wCnt_q + OutWidth'(1);
    end else if (bHs && !awHs) begin
      if (wCnt_q == '0) wErr = 1'b1;
      else              wCnt_d = wCnt_q - OutWidth'(1);
    end
  end

  always_comb begin
    rCnt_d = rCnt_q;
    rErr   = 1'b0;
    if (arHs && !rlHs) begin
      if (rCnt_q == MaxPending) rErr = 1'b1;
      else                      rCnt_d = rCnt_q + OutWidth'(1);
    end else if (rlHs && !arHs) begin
      if (rCnt_q == '0) rErr = 1'b1;
      else              rCnt_d = rCnt_q - OutWidth'(1);
    end
  end

  // Saturating byte accumulation; the extra MSB catches the carry out.
  always_comb begin
    bytesSum = {1'b0, rBytesCur_q} + (rbHs ? {1'b0, BeatBytes} : '0);
    bytesSat = bytesSum[BytesWidth] ? '1 : bytesSum[BytesWidth-1:0];
  end

  // Period FSM. On the last cycle of a period the snapshot includes any
  // beat of that same cycle, and the current counter restarts from zero.
  always_comb begin
    state_d      = state_q;
    periodLeft_d = periodLeft_q;
    rBytesCur_d  = bytesSat;
    rBytes_d     = rBytes_q;
    case (state_q)
      IDLE: begin
        periodLeft_d = '0;
        if (enable_i && (period_i != '0)) begin
          state_d      = RUN;
          periodLeft_d = period_i;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d      = IDLE;
          periodLeft_d = '0;
        end else if (periodLeft_q == PeriodWidth'(1)) begin
          rBytes_d    = bytesSat;
          rBytesCur_d = '0;
          if (period_i == '0) begin
            state_d      = IDLE;
            periodLeft_d = '0;
          end else begin
            periodLeft_d = period_i;
          end
        end else begin
          periodLeft_d = periodLeft_q - PeriodWidth'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        periodLeft_d = '0;
      end
    endcase
    if (clear_i) begin
      state_d      = IDLE;
      periodLeft_d = '0;
      rBytesCur_d  = '0;
      rBytes_d     = '0;
    end
  end

  // Stall counters run only while something is outstanding and no progress
  // is seen; any R beat counts as read progress. The flag is set from the
  // registered count, so it rises one cycle after the limit is reached.
  always_comb begin
    timeoutOn = enable_i && (timeout_i != '0);
    wStall    = timeoutOn && (wCnt_q != '0) && !bHs;
    rStall    = timeoutOn && (rCnt_q != '0) && !rbHs;

    wTcnt_d = '0;
    if (wStall) wTcnt_d = (wTcnt_q < timeout_i) ? wTcnt_q + TimeoutWidth'(1) : wTcnt_q;
    rTcnt_d = '0;
    if (rStall) rTcnt_d = (rTcnt_q < timeout_i) ? rTcnt_q + TimeoutWidth'(1) : rTcnt_q;

    wFlag_d = wFlag_q | ((timeout_i != '0) && (wTcnt_q >= timeout_i));
    rFlag_d = rFlag_q | ((timeout_i != '0) && (rTcnt_q >= timeout_i));
    perr_d  = perr_q | wErr | rErr;

    if (clear_i) begin
      wTcnt_d = '0;
      rTcnt_d = '0;
      wFlag_d = 1'b0;
      rFlag_d = 1'b0;
      perr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      wCnt_q       <= '0;
      rCnt_q       <= '0;
      rBytesCur_q  <= '0;
      rBytes_q     <= '0;
      periodLeft_q <= '0;
      wTcnt_q      <= '0;
      rTcnt_q      <= '0;
      wFlag_q      <= 1'b0;
      rFlag_q      <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wCnt_q       <= wCnt_d;
      rCnt_q       <= rCnt_d;
      rBytesCur_q  <= rBytesCur_d;
      rBytes_q     <= rBytes_d;
      periodLeft_q <= periodLeft_d;
      wTcnt_q      <= wTcnt_d;
      rTcnt_q      <= rTcnt_d;
      wFlag_q      <= wFlag_d;
      rFlag_q      <= rFlag_d;
      perr_q       <= perr_d;
    end
  end

  assign w_outstanding_o  = wCnt_q;
  assign r_outstanding_o  = rCnt_q;
  assign r_bytes_cur_o    = rBytesCur_q;
  assign r_bytes_o        = rBytes_q;
  assign period_left_o    = periodLeft_q;
  assign w_timeout_o      = wFlag_q;
  assign r_timeout_o      = rFlag_q;
  assign protocol_error_o = perr_q;

endmodule

// File: tb/tb_axi_rt_resp_meter.sv
// ---------------------------------------------------------------------------
// tb_axi_rt_resp_meter
//
// Directed bench for axi_rt_resp_meter with DataWidth=64 (8 bytes per beat),
// NumPending=4 and 8-bit period/timeout/byte counters, so byte saturation
// is reachable at 255.
// ---------------------------------------------------------------------------
module tb_axi_rt_resp_meter;

  logic clock;
  logic resetN;
  axi_rt_resp_meter_pkg::req_t  monReq;
  axi_rt_resp_meter_pkg::resp_t monResp;
  logic       enable;
  logic       clear;
  logic [7:0] period;
  logic [7:0] timeout;
  logic [2:0] wOut;
  logic [2:0] rOut;
  logic [7:0] bytesCur;
  logic [7:0] bytesLast;
  logic [7:0] periodLeft;
  logic       wTimeout;
  logic       rTimeout;
  logic       protErr;

  int checks;
  int errors;

  axi_rt_resp_meter #(
    .DataWidth   (64),
    .NumPending  (4),
    .PeriodWidth (8),
    .TimeoutWidth(8),
    .BytesWidth  (8)
  ) dut (
    .clk_i           (clock),
    .rst_ni          (resetN),
    .mon_req_i       (monReq),
    .mon_resp_i      (monResp),
    .enable_i        (enable),
    .clear_i         (clear),
    .period_i        (period),
    .timeout_i       (timeout),
    .w_outstanding_o (wOut),
    .r_outstanding_o (rOut),
    .r_bytes_cur_o   (bytesCur),
    .r_bytes_o       (bytesLast),
    .period_left_o   (periodLeft),
    .w_timeout_o     (wTimeout),
    .r_timeout_o     (rTimeout),
    .protocol_error_o(protErr)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One cycle with the requested handshakes; outputs are sampled 1 unit
  // after the rising edge, then the handshakes are dropped again.
  task automatic applyStimulus(input logic aw, input logic b, input logic ar,
                               input logic rb, input logic rl);
    monReq.aw_valid  = aw;
    monResp.aw_ready = aw;
    monResp.b_valid  = b;
    monReq.b_ready   = b;
    monReq.ar_valid  = ar;
    monResp.ar_ready = ar;
    monResp.r_valid  = rb | rl;
    monReq.r_ready   = rb | rl;
    monResp.r.last   = rl;
    @(posedge clock);
    #1;
    monReq  = '0;
    monResp = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    resetN  = 1'b0;
    monReq  = '0;
    monResp = '0;
    enable  = 1'b0;
    clear   = 1'b0;
    period  = 8'd0;
    timeout = 8'd0;
    $display("[TB] start");

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
    idle(1);
    checkOutput("rst_wOut", wOut, 0);
    checkOutput("rst_rOut", rOut, 0);
    checkOutput("rst_bytesCur", bytesCur, 0);
    checkOutput("rst_bytes", bytesLast, 0);
    checkOutput("rst_periodLeft", periodLeft, 0);
    checkOutput("rst_flags", {wTimeout, rTimeout, protErr}, 0);

    // Reset mid-traffic: 3 writes outstanding, then async reset
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_wOut3", wOut, 3);
    resetN = 1'b0;
    #2;
    checkOutput("mid_rst_wOut", wOut, 0);
    checkOutput("mid_rst_perr", protErr, 0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("late_b_wOut", wOut, 0);
    checkOutput("late_b_perr", protErr, 1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    checkOutput("clr_perr", protErr, 0);

    // Simultaneous events and overflow at NumPending
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("sim_awb_wOut", wOut, 2);
    checkOutput("sim_awb_perr", protErr, 0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_wOut", wOut, 4);
    checkOutput("full_perr", protErr, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_wOut", wOut, 4);
    checkOutput("ovf_perr", protErr, 1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    checkOutput("clr_keeps_wOut", wOut, 4);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_wOut", wOut, 0);
    checkOutput("drain_perr", protErr, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("sim_arrl_rOut", rOut, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rl_rOut", rOut, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("r_unf_rOut", rOut, 0);
    checkOutput("r_unf_perr", protErr, 1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;

    // Byte saturation with metering disabled: 8 bytes per beat, 8-bit counter
    repeat (31) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sat_248", bytesCur, 248);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sat_255", bytesCur, 255);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sat_hold", bytesCur, 255);
    checkOutput("sat_period_idle", periodLeft, 0);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    checkOutput("sat_clr", bytesCur, 0);

    // Metering: period 10, five beats in the first period
    enable = 1'b1;
    period = 8'd10;
    idle(1);
    checkOutput("run_load", periodLeft, 10);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("run_left5", periodLeft, 5);
    checkOutput("run_cur40", bytesCur, 40);
    idle(4);
    checkOutput("run_left1", periodLeft, 1);
    checkOutput("run_prev0", bytesLast, 0);
    idle(1);
    checkOutput("snap1_bytes", bytesLast, 40);
    checkOutput("snap1_cur", bytesCur, 0);
    checkOutput("snap1_reload", periodLeft, 10);
    // Second period: beat on its first and its last cycle
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("snap2_bytes", bytesLast, 16);
    checkOutput("snap2_cur", bytesCur, 0);
    checkOutput("snap2_reload", periodLeft, 10);

    // Clear while running, then disable mid-period
    idle(1);
    checkOutput("pre_clr_left", periodLeft, 9);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    checkOutput("clr_left", periodLeft, 0);
    checkOutput("clr_bytes", bytesLast, 0);
    idle(1);
    checkOutput("rerun_left", periodLeft, 10);
    idle(1);
    enable = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("dis_left", periodLeft, 0);
    checkOutput("dis_wOut", wOut, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("dis_wOut_b", wOut, 0);

    // Read timeout: 16-cycle limit, metering off
    period  = 8'd0;
    timeout = 8'd16;
    enable  = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("to_rOut", rOut, 1);
    idle(16);
    checkOutput("to_r_16", rTimeout, 0);
    idle(1);
    checkOutput("to_r_17", rTimeout, 1);
    checkOutput("to_w_quiet", wTimeout, 0);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    checkOutput("to_clr_flag", rTimeout, 0);
    checkOutput("to_clr_rOut", rOut, 1);
    // A non-last beat restarts the stall count
    idle(9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(16);
    checkOutput("to_rb_16", rTimeout, 0);
    idle(1);
    checkOutput("to_rb_17", rTimeout, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("to_rl_rOut", rOut, 0);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;

    // Write timeout: disabling mid-stall resets the count
    timeout = 8'd4;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    idle(4);
    checkOutput("to_w_dis", wTimeout, 0);
    idle(1);
    checkOutput("to_w_set", wTimeout, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("to_w_b_wOut", wOut, 0);
    checkOutput("to_w_sticky", wTimeout, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
